// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point types and helpers for the FPU datapath blocks
package fp_pkg;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    function automatic int bias(int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set
    function automatic logic [63:0] qnan(int exp_w, int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    // Subnormals land in FP_ZERO because the datapath flushes them on input
    function automatic fp_class_t classify(logic exp_ones, logic exp_zero, logic frac_nz);
        return exp_ones ? (frac_nz ? FP_NAN : FP_INF) : exp_zero ? FP_ZERO : FP_NORM;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: normalise a raw mantissa product, round to nearest even, range-check and pack
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   sign,
    input  logic signed [EXP_W+1:0] exp_in,
    input  logic [2*MAN_W+1:0]     prod,
    output logic [EXP_W+MAN_W:0]   res,
    output fp_flags_t              flags
);

    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W + 2)'((1 << EXP_W) - 1);

    logic                    hi;
    logic                    guard;
    logic                    sticky;
    logic                    carry;
    logic                    ovf;
    logic                    unf;
    logic [MAN_W-1:0]        frac;
    logic [MAN_W:0]          rounded;
    logic signed [EXP_W+1:0] e_fin;

    // Pick the kept window by the product MSB, round, and fold a rounding carry into the exponent
    always_comb begin
        hi      = prod[PW-1];
        frac    = hi ? prod[PW-2 -: MAN_W] : prod[PW-3 -: MAN_W];
        guard   = hi ? prod[MAN_W] : prod[MAN_W-1];
        sticky  = hi ? |prod[MAN_W-1:0] : |prod[MAN_W-2:0];
        rounded = {1'b0, frac} + (MAN_W + 1)'(guard & (sticky | frac[0]));
        carry   = rounded[MAN_W];
        e_fin   = exp_in + (EXP_W + 2)'(hi) + (EXP_W + 2)'(carry);
        ovf     = e_fin >= E_MAX;
        unf     = e_fin <= 0;
        res     = ovf ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                  unf ? {sign, {(EXP_W + MAN_W){1'b0}}} :
                        {sign, e_fin[EXP_W-1:0], rounded[MAN_W-1:0]};
        flags   = '{invalid: 1'b0, overflow: ovf, underflow: unf, inexact: ovf | unf | guard | sticky};
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage IEEE-754 multiplier with valid/ready flow control, RNE and flags
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] op,
    output logic [3:0]           flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic [W-1:0] QNAN = W'(qnan(EXP_W, MAN_W));
    localparam logic signed [EXP_W+1:0] BIAS = (EXP_W + 2)'(bias(EXP_W));

    logic advance;

    fp_class_t  ca;
    fp_class_t  cb;
    logic       sign0;
    logic       special0;
    logic       any_nan;
    logic       inf_zero;
    logic       any_inf;
    logic       snan;
    logic [W-1:0] spec_res0;
    fp_flags_t  spec_flags0;

    logic             v1;
    logic             s1;
    logic             sp1;
    logic [W-1:0]     sr1;
    fp_flags_t        sf1;
    logic [EXP_W-1:0] ea1;
    logic [EXP_W-1:0] eb1;
    logic [MAN_W-1:0] fa1;
    logic [MAN_W-1:0] fb1;

    logic                    v2;
    logic                    s2;
    logic                    sp2;
    logic [W-1:0]            sr2;
    fp_flags_t               sf2;
    logic signed [EXP_W+1:0] e2;
    logic [PW-1:0]           p2;

    logic [W-1:0] rp_res;
    fp_flags_t    rp_flags;

    // The whole pipe moves as one unit whenever the output slot is free or being drained
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // Classify operands and resolve NaN/Inf/zero results so they can ride alongside the arithmetic
    always_comb begin
        ca          = classify(&a[W-2:MAN_W], a[W-2:MAN_W] == '0, |a[MAN_W-1:0]);
        cb          = classify(&b[W-2:MAN_W], b[W-2:MAN_W] == '0, |b[MAN_W-1:0]);
        sign0       = a[W-1] ^ b[W-1];
        any_nan     = ca == FP_NAN || cb == FP_NAN;
        inf_zero    = (ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF);
        any_inf     = ca == FP_INF || cb == FP_INF;
        snan        = (ca == FP_NAN && !a[MAN_W-1]) || (cb == FP_NAN && !b[MAN_W-1]);
        special0    = ca != FP_NORM || cb != FP_NORM;
        spec_res0   = (any_nan || inf_zero) ? QNAN :
                      any_inf ? {sign0, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                                {sign0, {(W - 1){1'b0}}};
        spec_flags0 = '{invalid: any_nan ? snan : inf_zero, overflow: 1'b0, underflow: 1'b0, inexact: 1'b0};
    end

    fp_round_pack #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round_pack (
        .sign  (s2),
        .exp_in(e2),
        .prod  (p2),
        .res   (rp_res),
        .flags (rp_flags)
    );

    // Stage registers: S1 operands/special result, S2 product/exponent, S3 packed result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            op        <= '0;
            flags     <= '0;
        end else if (advance) begin
            v1        <= in_valid;
            s1        <= sign0;
            sp1       <= special0;
            sr1       <= spec_res0;
            sf1       <= spec_flags0;
            ea1       <= a[W-2:MAN_W];
            eb1       <= b[W-2:MAN_W];
            fa1       <= a[MAN_W-1:0];
            fb1       <= b[MAN_W-1:0];
            v2        <= v1;
            s2        <= s1;
            sp2       <= sp1;
            sr2       <= sr1;
            sf2       <= sf1;
            e2        <= {2'b00, ea1} + {2'b00, eb1} - BIAS;
            p2        <= PW'({1'b1, fa1}) * PW'({1'b1, fb1});
            out_valid <= v2;
            op        <= sp2 ? sr2 : rp_res;
            flags     <= sp2 ? sf2 : rp_flags;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: scoreboard bench for the FP32 and FP16 builds of fp_mul_pipe
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] op;
    logic [3:0]  flags;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [15:0] op16;
    logic [3:0]  flags16;

    int   checks = 0;
    int   errors = 0;
    bit   bp = 1'b0;
    logic [35:0] q[$];
    logic [19:0] q16[$];

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .op(op), .flags(flags)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
        .out_valid(out_valid16), .out_ready(out_ready16), .op(op16), .flags(flags16)
    );

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic real to_real(logic [31:0] x);
        return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'h0});
    endfunction

    // Exact double product of two FP32 normals, then rounded to FP32 with RNE, FTZ and overflow-to-Inf
    function automatic logic [35:0] ref32(logic [31:0] x, logic [31:0] y);
        logic        s, xn, yn, xi, yi, xz, yz, up;
        logic [63:0] bits;
        logic [23:0] keep;
        logic [28:0] rem;
        int          e;
        s  = x[31] ^ y[31];
        xn = x[30:23] == 8'hFF && x[22:0] != 0;
        yn = y[30:23] == 8'hFF && y[22:0] != 0;
        xi = x[30:23] == 8'hFF && x[22:0] == 0;
        yi = y[30:23] == 8'hFF && y[22:0] == 0;
        xz = x[30:23] == 8'h00;
        yz = y[30:23] == 8'h00;
        if (xn || yn) return {(xn && !x[22]) || (yn && !y[22]), 3'b000, 32'h7FC00000};
        if ((xi && yz) || (xz && yi)) return {4'b1000, 32'h7FC00000};
        if (xi || yi) return {4'b0000, s, 8'hFF, 23'h0};
        if (xz || yz) return {4'b0000, s, 31'h0};
        bits = $realtobits(to_real(x) * to_real(y));
        e    = int'(bits[62:52]) - 896;
        keep = {1'b0, bits[51:29]};
        rem  = bits[28:0];
        up   = rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0]);
        keep = keep + 24'(up);
        if (keep[23]) begin
            e++;
            keep = '0;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, rem != 0, s, e[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] rnd_norm(int lo, int hi);
        return {1'($urandom), 8'($urandom_range(hi, lo)), 23'($urandom)};
    endfunction

    task automatic issue(logic [31:0] x, logic [31:0] y, logic [35:0] exp);
        int n = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL fp32 in_ready timeout: got 0 expected 1");
        end else q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue16(logic [15:0] x, logic [15:0] y, logic [19:0] exp);
        int n = 0;
        in_valid16 = 1'b1;
        a16 = x;
        b16 = y;
        @(negedge clk);
        while (!in_ready16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready16) begin
            checks++;
            errors++;
            $display("FAIL fp16 in_ready timeout: got 0 expected 1");
        end else q16.push_back(exp);
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp ? 1'($urandom) : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fp32 unexpected output: got %h/%b expected none", op, flags);
            end else check("fp32 result", {flags, op}, q.pop_front());
        end
        if (!rst && out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fp16 unexpected output: got %h/%b expected none", op16, flags16);
            end else check("fp16 result", {flags16, op16}, q16.pop_front());
        end
    end

    logic [31:0] dir_a[9] = '{32'h3F800001, 32'h7F000000, 32'h00800000, 32'hFF800000,
                              32'h7F800001, 32'h80000000, 32'h7FC00000, 32'h00000001, 32'hFF800000};
    logic [31:0] dir_b[9] = '{32'h3FC00000, 32'h7F000000, 32'h00800000, 32'h00000000,
                              32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
    logic [35:0] dir_e[9] = '{{4'b0001, 32'h3FC00002}, {4'b0101, 32'h7F800000}, {4'b0011, 32'h00000000},
                              {4'b1000, 32'h7FC00000}, {4'b1000, 32'h7FC00000}, {4'b0000, 32'h80000000},
                              {4'b0000, 32'h7FC00000}, {4'b0000, 32'h00000000}, {4'b0000, 32'hFF800000}};

    initial begin
        logic [31:0] x, y;
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset op", op, 0);
        check("reset flags", flags, 0);
        check("reset in_ready", in_ready, 1);
        check("reset in_ready16", in_ready16, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(32'h40400000, 32'h40000000, {4'b0000, 32'h40C00000});
        @(negedge clk);
        check("latency cycle1 out_valid", out_valid, 0);
        @(negedge clk);
        check("latency cycle2 out_valid", out_valid, 0);
        @(negedge clk);
        check("latency cycle3 out_valid", out_valid, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) issue(dir_a[i], dir_b[i], dir_e[i]);
        issue16(16'h4200, 16'h4000, {4'b0000, 16'h4600});
        issue16(16'h7C00, 16'h0000, {4'b1000, 16'h7E00});

        bp = 1'b1;
        for (int i = 0; i < 12; i++) begin
            x = rnd_norm(64, 190);
            y = rnd_norm(64, 190);
            issue(x, y, ref32(x, y));
        end

        rst = 1'b1;
        @(posedge clk);
        q.delete();
        q16.delete();
        @(negedge clk);
        check("mid reset out_valid", out_valid, 0);
        check("mid reset in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            x = i < 20 ? rnd_norm(64, 190) : rnd_norm(1, 254);
            y = i < 20 ? rnd_norm(64, 190) : rnd_norm(1, 254);
            issue(x, y, ref32(x, y));
        end

        n = 0;
        while ((q.size() != 0 || q16.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain pending", q.size() + q16.size(), 0);
        bp = 1'b0;
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
